// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with start/done handshake.
// Optional build macro BCD_SEQ_CONV_SATURATE_EN: overflowed results read as all nines.
module bcd_seq_conv #(
  parameter int BIN_WIDTH = 13,
  parameter int DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_nxt;
  logic [BCD_W-1:0]     work_q, work_adj, work_nxt, result;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_acc_q, carry, ovf_nxt;
  logic                 load, shift_en, finish;

  // One double-dabble step: add 3 to every digit >= 5, then shift {work, bin} left.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    work_adj = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5)
        work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
    {carry, work_nxt, bin_nxt} = {work_adj, bin_q, 1'b0};
    ovf_nxt = ovf_acc_q | carry;
`ifdef BCD_SEQ_CONV_SATURATE_EN
    result = ovf_nxt ? {DIGITS{4'h9}} : work_nxt;
`else
    result = work_nxt;
`endif
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    finish   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        // The last shift happens on the edge that takes the counter from 1 to 0.
        if (cnt_q == CNT_W'(1)) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (finish) begin
        bcd_out  <= result;
        overflow <= ovf_nxt;
      end
    end
  end

  // NOTE: the working datapath is left unreset; it is always reloaded before it is observed.
  always_ff @(posedge clk) begin
    if (load) begin
      bin_q     <= bin_in;
      work_q    <= '0;
      ovf_acc_q <= 1'b0;
      cnt_q     <= CNT_W'(BIN_WIDTH);
    end else if (shift_en) begin
      bin_q     <= bin_nxt;
      work_q    <= work_nxt;
      ovf_acc_q <= ovf_nxt;
      cnt_q     <= cnt_q - CNT_W'(1);
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);

endmodule
